// File: rtl/serial_master_pkg.sv
// Shared control definitions for the serial master and its downstream serial_ctrl:
// word/command widths, command encodings, wait lengths and the serial_ctrl state type.
package serial_master_pkg;

  localparam int DATA_LEN = 8;
  localparam int CMD_LEN  = 3;
  localparam int RCV_WAIT = 1;
  localparam int SND_WAIT = 2;
  localparam int CMD_WAIT = 3;

  typedef enum logic [CMD_LEN-1:0] {
    RESET_CMD     = 3'b001,
    START_RCV_CMD = 3'b010,
    START_SND_CMD = 3'b011,
    UPDATE_CMD    = 3'b100
  } ctrl_cmd_t;

  typedef enum logic [2:0] {
    RESET_ST,
    IDLE_ST,
    RCV_ST,
    SND_ST,
    UPDATE_ST
  } ctrl_state_t;

  // Unknown encodings fall into the no-data wait length.
  function automatic logic [7:0] wait_len(input ctrl_cmd_t cmd);
    case (cmd)
      START_RCV_CMD: return 8'(RCV_WAIT);
      START_SND_CMD: return 8'(SND_WAIT);
      default:       return 8'(CMD_WAIT);
    endcase
  endfunction

endpackage

// File: rtl/sm_shift_reg.sv
// Data shift register: parallel load, MSB-first shift-out and LSB-first shift-in.
module sm_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_out_en,
  input  logic             shift_in_en,
  input  logic             serial_in,
  output logic             msb,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_out_en) begin
      q <= {q[WIDTH-2:0], 1'b0};
    end else if (shift_in_en) begin
      q <= {serial_in, q[WIDTH-1:1]};
    end
  end

  assign msb = q[WIDTH-1];

endmodule

// File: rtl/serial_master.sv
// Serial master: frames a command (and optional data word) onto a single bidirectional
// line as START, CMD, GAP, WAIT, then TX or RX, then TAIL.
module serial_master
  import serial_master_pkg::*;
#(
  parameter int DATA_LEN = serial_master_pkg::DATA_LEN,
  parameter int CMD_LEN  = serial_master_pkg::CMD_LEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  ctrl_cmd_t           req_cmd,
  input  logic [DATA_LEN-1:0] req_data,
  output logic                done,
  output logic                rsp_valid,
  output logic [DATA_LEN-1:0] rsp_data,
  inout  wire                 data_inout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_CMD   = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_TX    = 3'd5;
  localparam logic [2:0] S_RX    = 3'd6;
  localparam logic [2:0] S_TAIL  = 3'd7;

  logic [2:0]          state;
  logic [7:0]          cnt;
  ctrl_cmd_t           cmd_q;
  logic [CMD_LEN-1:0]  cmd_sh;
  logic [DATA_LEN-1:0] rsp_q;
  logic [DATA_LEN-1:0] sh_q;
  logic                sh_msb;
  logic                accept, is_rcv, is_snd;
  logic                last_cmd, last_wait, last_data;
  logic                drive_en, line_bit;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign is_rcv    = (cmd_q == START_RCV_CMD);
  assign is_snd    = (cmd_q == START_SND_CMD);
  assign last_cmd  = (cnt == 8'(CMD_LEN - 1));
  assign last_data = (cnt == 8'(DATA_LEN - 1));
  assign last_wait = (state == S_WAIT) && (cnt == wait_len(cmd_q) - 8'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      cmd_q  <= RESET_CMD;
      cmd_sh <= '0;
      rsp_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (accept) begin
            cmd_q  <= req_cmd;
            cmd_sh <= req_cmd;
            state  <= S_START;
          end
        end
        S_START: begin
          cnt   <= '0;
          state <= S_CMD;
        end
        S_CMD: begin
          cmd_sh <= {cmd_sh[CMD_LEN-2:0], 1'b0};
          if (last_cmd) begin
            cnt   <= '0;
            state <= S_GAP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_GAP: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (last_wait) begin
            cnt   <= '0;
            state <= is_rcv ? S_TX : (is_snd ? S_RX : S_IDLE);
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_TX, S_RX: begin
          if (last_data) begin
            cnt   <= '0;
            state <= S_TAIL;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_TAIL: begin
          if (is_snd) rsp_q <= sh_q;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sm_shift_reg #(.WIDTH(DATA_LEN)) u_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (accept),
    .load_data   (req_data),
    .shift_out_en(state == S_TX),
    .shift_in_en (state == S_RX),
    .serial_in   (data_inout),
    .msb         (sh_msb),
    .q           (sh_q)
  );

  always_comb begin
    line_bit = 1'b0;
    case (state)
      S_START: line_bit = 1'b1;
      S_CMD:   line_bit = cmd_sh[CMD_LEN-1];
      S_TX:    line_bit = sh_msb;
      default: line_bit = 1'b0;
    endcase
  end

  // The line stays released through the TAIL of a read, so the slave never fights us.
  assign drive_en   = !((state == S_RX) || ((state == S_TAIL) && is_snd));
  assign data_inout = drive_en ? line_bit : 1'bz;

  // Outputs are gated by rst_n so an aborted transaction never reports completion.
  assign done      = rst_n && ((last_wait && !is_rcv && !is_snd) || (state == S_TAIL));
  assign rsp_valid = rst_n && (state == S_TAIL) && is_snd;
  assign rsp_data  = rsp_valid ? sh_q : rsp_q;

endmodule

// File: tb/tb_serial_master.sv
// Directed bench for serial_master; a tb-side driver plus pullup stands in for the slave.
module tb_serial_master;
  import serial_master_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  ctrl_cmd_t  req_cmd;
  logic [7:0] req_data;
  logic       done;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  wire        line;
  logic       slave_en;
  logic       slave_bit;
  int         checks = 0;
  int         passes = 0;

  assign line = slave_en ? slave_bit : 1'bz;
  pullup (line);

  always #5 clk = ~clk;

  serial_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_data  (req_data),
    .done      (done),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .data_inout(line)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_cmd = RESET_CMD; req_data = 8'h00;
    slave_en = 1'b0; slave_bit = 1'b0;
    tick(); tick();
    checks++; if (line !== 1'b0) $display("[TB] FAIL reset_line: got %b expected 0", line); else passes++;
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); else passes++;
    checks++; if (rsp_data !== 8'h00) $display("[TB] FAIL reset_rsp_data: got %h expected 00", rsp_data); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else passes++;
    rst_n = 1'b1;
    tick();
  endtask

  // START=1, cmd 001, GAP=0, three WAIT zeros; done in the 8th frame cycle.
  task automatic test_reset_cmd();
    logic [7:0] exp_line;
    exp_line = 8'b1_001_0_000;
    req_valid = 1'b1; req_cmd = RESET_CMD;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      checks++; if (line !== exp_line[7-c]) $display("[TB] FAIL rst_cmd_line[%0d]: got %b expected %b", c, line, exp_line[7-c]); else passes++;
      checks++; if (done !== (c == 7)) $display("[TB] FAIL rst_cmd_done[%0d]: got %b expected %b", c, done, (c == 7)); else passes++;
      checks++; if (req_ready !== 1'b0) $display("[TB] FAIL rst_cmd_ready[%0d]: got %b expected 0", c, req_ready); else passes++;
      tick();
    end
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL rst_cmd_idle_ready: got %b expected 1", req_ready); else passes++;
    checks++; if (line !== 1'b0) $display("[TB] FAIL rst_cmd_idle_line: got %b expected 0", line); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL rst_cmd_idle_done: got %b expected 0", done); else passes++;
  endtask

  // START, cmd 010, GAP, 1 WAIT, data 08 MSB first, TAIL.
  task automatic test_rcv();
    logic [14:0] exp_line;
    exp_line = {1'b1, 3'b010, 1'b0, 1'b0, 8'h08, 1'b0};
    req_valid = 1'b1; req_cmd = START_RCV_CMD; req_data = 8'h08;
    tick();
    req_valid = 1'b0; req_data = 8'hFF;
    for (int c = 0; c < 15; c++) begin
      checks++; if (line !== exp_line[14-c]) $display("[TB] FAIL rcv_line[%0d]: got %b expected %b", c, line, exp_line[14-c]); else passes++;
      checks++; if (done !== (c == 14)) $display("[TB] FAIL rcv_done[%0d]: got %b expected %b", c, done, (c == 14)); else passes++;
      checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL rcv_rsp_valid[%0d]: got %b expected 0", c, rsp_valid); else passes++;
      tick();
    end
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL rcv_idle_ready: got %b expected 1", req_ready); else passes++;
    checks++; if (rsp_data !== 8'h00) $display("[TB] FAIL rcv_rsp_data: got %h expected 00", rsp_data); else passes++;
  endtask

  // Slave returns A5 LSB first in cycles 7..14; cycle 15 (TAIL) is undriven and pulls up.
  task automatic test_snd();
    logic [6:0] exp_head;
    logic [7:0] word;
    logic       exp;
    exp_head = {1'b1, 3'b011, 1'b0, 1'b0, 1'b0};
    word = 8'hA5;
    req_valid = 1'b1; req_cmd = START_SND_CMD; req_data = 8'h00;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      slave_en  = (c >= 7 && c <= 14);
      slave_bit = (c >= 7 && c <= 14) ? word[c-7] : 1'b0;
      #1;
      exp = (c < 7) ? exp_head[6-c] : ((c <= 14) ? word[c-7] : 1'b1);
      checks++; if (line !== exp) $display("[TB] FAIL snd_line[%0d]: got %b expected %b", c, line, exp); else passes++;
      checks++; if (done !== (c == 15)) $display("[TB] FAIL snd_done[%0d]: got %b expected %b", c, done, (c == 15)); else passes++;
      checks++; if (rsp_valid !== (c == 15)) $display("[TB] FAIL snd_rsp_valid[%0d]: got %b expected %b", c, rsp_valid, (c == 15)); else passes++;
      if (c == 15) begin
        checks++; if (rsp_data !== 8'hA5) $display("[TB] FAIL snd_rsp_data_tail: got %h expected a5", rsp_data); else passes++;
      end
      tick();
    end
    #1;
    checks++; if (line !== 1'b0) $display("[TB] FAIL snd_reclaim_line: got %b expected 0", line); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL snd_idle_rsp_valid: got %b expected 0", rsp_valid); else passes++;
    checks++; if (rsp_data !== 8'hA5) $display("[TB] FAIL snd_rsp_data_hold: got %h expected a5", rsp_data); else passes++;
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL snd_idle_ready: got %b expected 1", req_ready); else passes++;
  endtask

  // Reset in the 4th RX cycle: the line must be driven low right after, with no completion.
  task automatic test_rx_reset();
    logic [7:0] word;
    word = 8'hFF;
    req_valid = 1'b1; req_cmd = START_SND_CMD;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      slave_en  = (c >= 7);
      slave_bit = (c >= 7) ? word[c-7] : 1'b0;
      tick();
    end
    slave_bit = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if (done !== 1'b0) $display("[TB] FAIL rxrst_done_during: got %b expected 0", done); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL rxrst_rsp_valid_during: got %b expected 0", rsp_valid); else passes++;
    tick();
    slave_en = 1'b0;
    #1;
    checks++; if (line !== 1'b0) $display("[TB] FAIL rxrst_line: got %b expected 0", line); else passes++;
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL rxrst_ready: got %b expected 1", req_ready); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL rxrst_done: got %b expected 0", done); else passes++;
    checks++; if (rsp_valid !== 1'b0) $display("[TB] FAIL rxrst_rsp_valid: got %b expected 0", rsp_valid); else passes++;
    checks++; if (rsp_data !== 8'h00) $display("[TB] FAIL rxrst_rsp_data: got %h expected 00", rsp_data); else passes++;
    rst_n = 1'b1;
    tick();
  endtask

  // RESET_CMD then undefined 3'b110 with req_valid held; one IDLE cycle between frames.
  task automatic test_back_to_back();
    logic [7:0] exp1;
    logic [7:0] exp2;
    exp1 = 8'b1_001_0_000;
    exp2 = 8'b1_110_0_000;
    req_valid = 1'b1; req_cmd = RESET_CMD;
    tick();
    req_cmd = ctrl_cmd_t'(3'b110);
    for (int c = 0; c < 8; c++) begin
      checks++; if (line !== exp1[7-c]) $display("[TB] FAIL b2b1_line[%0d]: got %b expected %b", c, line, exp1[7-c]); else passes++;
      checks++; if (req_ready !== 1'b0) $display("[TB] FAIL b2b1_ready[%0d]: got %b expected 0", c, req_ready); else passes++;
      checks++; if (done !== (c == 7)) $display("[TB] FAIL b2b1_done[%0d]: got %b expected %b", c, done, (c == 7)); else passes++;
      tick();
    end
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL b2b_gap_ready: got %b expected 1", req_ready); else passes++;
    checks++; if (line !== 1'b0) $display("[TB] FAIL b2b_gap_line: got %b expected 0", line); else passes++;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      checks++; if (line !== exp2[7-c]) $display("[TB] FAIL b2b2_line[%0d]: got %b expected %b", c, line, exp2[7-c]); else passes++;
      checks++; if (req_ready !== 1'b0) $display("[TB] FAIL b2b2_ready[%0d]: got %b expected 0", c, req_ready); else passes++;
      checks++; if (done !== (c == 7)) $display("[TB] FAIL b2b2_done[%0d]: got %b expected %b", c, done, (c == 7)); else passes++;
      tick();
    end
    checks++; if (req_ready !== 1'b1) $display("[TB] FAIL b2b_end_ready: got %b expected 1", req_ready); else passes++;
    checks++; if (line !== 1'b0) $display("[TB] FAIL b2b_end_line: got %b expected 0", line); else passes++;
  endtask

  initial begin
    test_reset();
    test_reset_cmd();
    test_rcv();
    test_snd();
    test_rx_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
